icache_assoc: RTL and testbench

Parametrised N-way set-associative instruction cache between the IF stage and the memory controller, replacing the single-way direct-mapped cache. Hits are returned combinationally in the request cycle. Misses run a registered refill state machine that holds a request to memory, installs the returned word into a victim way, and replays it to IF. The cache also supports a single-cycle flush for `fence.i` and redirect cleanup.

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_way.sv | 50 +++++
 rtl/icache_assoc.sv | 149 ++++++++++++++
 tb/tb_icache_assoc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// default geometry and address split helpers.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MISS = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_SET_BITS = 6;
   localparam int DEF_IDX_W    = DEF_SET_BITS;
   localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_SET_BITS - 2;

   function automatic int tag_width(input int addr_w, input int set_bits);
      return addr_w - set_bits - 2;
   endfunction

   // Callers zero-extend the address to 64 bits and cast the result to their width.
   function automatic logic [63:0] addr_index(input logic [63:0] addr, input int set_bits);
      return (addr >> 2) & ((64'd1 << set_bits) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int set_bits);
      return addr >> (set_bits + 2);
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data per set, combinational
// lookup, single write port and a whole-way flush.
module icache_way #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 24
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              en,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              hit,
   output logic [DATA_W-1:0] data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_vld
);

   localparam int SETS = 1 << IDX_W;

   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [DATA_W-1:0] data_q [SETS];

   // Flush wins over a same-edge install so a flushed line never reappears.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid <= '0;
      end else if (en) begin
         if (flush)   valid         <= '0;
         else if (we) valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (en && we) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign hit    = valid[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign data   = data_q[rd_idx];
   assign wr_vld = valid[wr_idx];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with zero-latency hits and a
// blocking refill FSM. Define ICACHE_STAT_EN for hit/miss counters.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SET_BITS = 6,
   parameter int WAYS     = 2
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_rdy_o,
   output logic [DATA_W-1:0] if_data_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_valid_i,
   input  logic [DATA_W-1:0] mem_data_i
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int IDX_W = SET_BITS;
   localparam int TAG_W = tag_width(ADDR_W, SET_BITS);
   localparam int SETS  = 1 << SET_BITS;
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   state_e            state;
   logic              flush_pend;
   logic [ADDR_W-1:0] miss_addr;
   logic [DATA_W-1:0] fill_data;
   logic [PTR_W-1:0]  rr_ptr [SETS];

   logic [IDX_W-1:0]  lk_idx, fill_idx;
   logic [TAG_W-1:0]  lk_tag, fill_tag;
   logic [WAYS-1:0]   way_hit, way_vld, way_we;
   logic [DATA_W-1:0] way_data [WAYS];
   logic              hit_any, all_vld;
   logic [DATA_W-1:0] hit_data;
   logic [PTR_W-1:0]  victim;
   logic              idle_hit, start_miss, resp_hit, fill_fire, install;

   assign lk_idx   = IDX_W'(addr_index(64'(if_addr_i), SET_BITS));
   assign lk_tag   = TAG_W'(addr_tag(64'(if_addr_i), SET_BITS));
   assign fill_idx = IDX_W'(addr_index(64'(miss_addr), SET_BITS));
   assign fill_tag = TAG_W'(addr_tag(64'(miss_addr), SET_BITS));

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_way #(.DATA_W(DATA_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
         .clk_in  (clk_in),
         .rst_n_in(rst_n_in),
         .en      (rdy_in),
         .flush   (flush_in),
         .rd_idx  (lk_idx),
         .rd_tag  (lk_tag),
         .hit     (way_hit[w]),
         .data    (way_data[w]),
         .we      (way_we[w]),
         .wr_idx  (fill_idx),
         .wr_tag  (fill_tag),
         .wr_data (mem_data_i),
         .wr_vld  (way_vld[w])
      );
      assign way_we[w] = install && (victim == PTR_W'(w));
   end

   // Victim: lowest invalid way in the fill set, otherwise the round-robin pointer.
   always_comb begin
      hit_any  = 1'b0;
      hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w] && !hit_any) begin
            hit_any  = 1'b1;
            hit_data = way_data[w];
         end
      end
      all_vld = &way_vld;
      victim  = rr_ptr[fill_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!way_vld[w]) victim = PTR_W'(w);
      end
   end

   assign idle_hit   = rdy_in && (state == ST_IDLE) && if_req_i && !flush_in && hit_any;
   assign start_miss = rdy_in && (state == ST_IDLE) && if_req_i && !flush_in && !hit_any;
   assign resp_hit   = rdy_in && (state == ST_RESP) && if_req_i && (if_addr_i == miss_addr);
   assign fill_fire  = rdy_in && (state == ST_MISS) && mem_valid_i;
   assign install    = fill_fire && !flush_pend && !flush_in;

   assign if_rdy_o   = idle_hit || resp_hit;
   assign if_data_o  = idle_hit ? hit_data : (resp_hit ? fill_data : '0);
   assign mem_req_o  = (state == ST_MISS);
   assign mem_addr_o = mem_req_o ? miss_addr : '0;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= ST_IDLE;
         flush_pend <= 1'b0;
      end else if (rdy_in) begin
         unique case (state)
            ST_IDLE: if (start_miss) state <= ST_MISS;
            ST_MISS: begin
               if (flush_in)    flush_pend <= 1'b1;
               if (mem_valid_i) state      <= ST_RESP;
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               flush_pend <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (start_miss) miss_addr <= if_addr_i;
      if (fill_fire)  fill_data <= mem_data_i;
   end

   // The pointer only advances when a valid line is displaced.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
      end else if (install && all_vld) begin
         rr_ptr[fill_idx] <= (rr_ptr[fill_idx] == PTR_W'(WAYS - 1)) ? '0
                                                                  : rr_ptr[fill_idx] + PTR_W'(1);
      end
   end

`ifdef ICACHE_STAT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (idle_hit && (hit_cnt_o != 32'hFFFF_FFFF))    hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (start_miss && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (2 ways, 64 sets) against a set/way
// reference model; counter checks are compiled in with ICACHE_STAT_EN.
module tb_icache_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 64;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, flush_in, if_req_i, mem_valid_i;
   logic [31:0] if_addr_i, mem_data_i;
   logic        if_rdy_o, mem_req_o;
   logic [31:0] if_data_o, mem_addr_o;
`ifdef ICACHE_STAT_EN
   logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

   icache_assoc #(.ADDR_W(32), .DATA_W(32), .SET_BITS(6), .WAYS(WAYS)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .flush_in   (flush_in),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .if_rdy_o   (if_rdy_o),
      .if_data_o  (if_data_o),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_valid_i(mem_valid_i),
      .mem_data_i (mem_data_i)
`ifdef ICACHE_STAT_EN
      ,
      .hit_cnt_o  (hit_cnt_o),
      .miss_cnt_o (miss_cnt_o)
`endif
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;
   int n_hit = 0;
   int n_miss = 0;

   // Reference model: which tags are resident in each set and the replacement pointer.
   bit          mv [SETS][WAYS];
   logic [23:0] mt [SETS][WAYS];
   int          mp [SETS];

   typedef struct {
      logic [31:0] addr;
      int          lat;
      bit          hit;
   } vec_t;
   vec_t tbl [10];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'hC0DE_0000) ^ (a << 16) ^ 32'h0000_5A5A;
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int s = int'(a[7:2]);
      for (int w = 0; w < WAYS; w++)
         if (mv[s][w] && mt[s][w] == a[31:8]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_install(input logic [31:0] a);
      int s = int'(a[7:2]);
      for (int w = 0; w < WAYS; w++) begin
         if (!mv[s][w]) begin
            mv[s][w] = 1'b1;
            mt[s][w] = a[31:8];
            return;
         end
      end
      mt[s][mp[s]] = a[31:8];
      mp[s] = (mp[s] + 1) % WAYS;
   endfunction

   function automatic void model_flush();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
   endfunction

   function automatic void model_reset();
      model_flush();
      for (int s = 0; s < SETS; s++) mp[s] = 0;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One fetch from IDLE. On a miss, memory answers after 'lat' extra request
   // cycles; flush_in is pulsed on refill cycle 'flush_at' (negative = never).
   task automatic fetch(input logic [31:0] a, input int lat, input bit exp_hit, input int flush_at);
      logic [31:0] w = mem_word(a);
      @(negedge clk_in);
      if_req_i = 1'b1; if_addr_i = a; flush_in = 1'b0; mem_valid_i = 1'b0;
      #1;
      chk1("rdy_t0", if_rdy_o, exp_hit);
      if (exp_hit) begin
         chk32("hit_data", if_data_o, w);
         chk1("hit_no_mreq", mem_req_o, 1'b0);
         n_hit++;
      end else begin
         n_miss++;
         for (int c = 0; c <= lat; c++) begin
            @(negedge clk_in);
            flush_in = (c == flush_at);
            mem_valid_i = (c == lat);
            mem_data_i = (c == lat) ? w : $urandom;
            #1;
            chk1("mreq_wait", mem_req_o, 1'b1);
            chk32("maddr_wait", mem_addr_o, a);
            chk1("rdy_wait", if_rdy_o, 1'b0);
         end
         @(negedge clk_in);
         mem_valid_i = 1'b0; flush_in = 1'b0; mem_data_i = $urandom;
         #1;
         chk1("resp_rdy", if_rdy_o, 1'b1);
         chk32("resp_data", if_data_o, w);
         chk1("resp_no_mreq", mem_req_o, 1'b0);
         if (flush_at >= 0 && flush_at <= lat) model_flush();
         else model_install(a);
      end
   endtask

   task automatic idle_flush(input logic [31:0] a);
      @(negedge clk_in);
      flush_in = 1'b1; if_req_i = 1'b1; if_addr_i = a;
      #1;
      chk1("flush_cycle_rdy", if_rdy_o, 1'b0);
      @(negedge clk_in);
      flush_in = 1'b0; if_req_i = 1'b0;
      #1;
      chk1("flush_no_miss", mem_req_o, 1'b0);
      model_flush();
   endtask

   initial begin
      logic [31:0] w5;
      rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_req_i = 1'b0;
      if_addr_i = '0; mem_valid_i = 1'b0; mem_data_i = '0;
      model_reset();

      tbl[0] = '{32'h0000_1000, 3, 1'b0};
      tbl[1] = '{32'h0000_1000, 0, 1'b1};
      tbl[2] = '{32'h0000_2000, 1, 1'b0};
      tbl[3] = '{32'h0000_3000, 2, 1'b0};
      tbl[4] = '{32'h0000_2000, 0, 1'b1};
      tbl[5] = '{32'h0000_1000, 0, 1'b0};
      tbl[6] = '{32'h0000_3000, 0, 1'b1};
      tbl[7] = '{32'h0000_1000, 0, 1'b1};
      tbl[8] = '{32'h0000_2000, 2, 1'b0};
      tbl[9] = '{32'h0000_1004, 1, 1'b0};

      repeat (3) @(negedge clk_in);
      #1;
      chk1("rst_rdy", if_rdy_o, 1'b0);
      chk1("rst_mreq", mem_req_o, 1'b0);
      chk32("rst_maddr", mem_addr_o, 32'h0);
      rst_n_in = 1'b1;
`ifdef ICACHE_STAT_EN
      chk32("rst_hitcnt", hit_cnt_o, 32'h0);
      chk32("rst_misscnt", miss_cnt_o, 32'h0);
`endif

      for (int i = 0; i < 10; i++) fetch(tbl[i].addr, tbl[i].lat, tbl[i].hit, -1);

      // Flush in IDLE: hit before, no response in the flush cycle, miss after.
      fetch(32'h0000_1000, 0, 1'b1, -1);
      idle_flush(32'h0000_1000);
      fetch(32'h0000_1000, 2, 1'b0, -1);

      // Flush while refilling 0x4000: data still delivered, line not kept.
      fetch(32'h0000_4000, 2, 1'b0, 1);
      fetch(32'h0000_4000, 1, 1'b0, -1);

      // Redirect from 0x5000 to 0x6000 while the 0x5000 refill is in flight.
      idle_flush(32'h0000_0000);
      w5 = mem_word(32'h0000_5000);
      @(negedge clk_in);
      if_req_i = 1'b1; if_addr_i = 32'h0000_5000;
      #1;
      chk1("redir_t0_rdy", if_rdy_o, 1'b0);
      n_miss++;
      @(negedge clk_in);
      if_addr_i = 32'h0000_6000;
      #1;
      chk32("redir_maddr_held", mem_addr_o, 32'h0000_5000);
      @(negedge clk_in);
      mem_valid_i = 1'b1; mem_data_i = w5;
      #1;
      chk1("redir_mreq", mem_req_o, 1'b1);
      @(negedge clk_in);
      mem_valid_i = 1'b0;
      #1;
      chk1("redir_no_resp", if_rdy_o, 1'b0);
      model_install(32'h0000_5000);
      fetch(32'h0000_6000, 1, 1'b0, -1);
      fetch(32'h0000_5000, 0, 1'b1, -1);

      // Global enable low suppresses a hit.
      @(negedge clk_in);
      rdy_in = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_5000;
      #1;
      chk1("rdy_low_no_hit", if_rdy_o, 1'b0);
      @(negedge clk_in);
      rdy_in = 1'b1;

      // Reset in the middle of a refill.
      if_addr_i = 32'h0000_7000;
      @(negedge clk_in);
      #1;
      chk1("pre_rst_mreq", mem_req_o, 1'b1);
      @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      chk1("midrst_mreq", mem_req_o, 1'b0);
      chk1("midrst_rdy", if_rdy_o, 1'b0);
`ifdef ICACHE_STAT_EN
      chk32("midrst_hitcnt", hit_cnt_o, 32'h0);
      chk32("midrst_misscnt", miss_cnt_o, 32'h0);
`endif
      model_reset();
      n_hit = 0; n_miss = 0;
      @(negedge clk_in);
      rst_n_in = 1'b1; if_req_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
      #1;
      chk1("stray_valid_rdy", if_rdy_o, 1'b0);
      @(negedge clk_in);
      mem_valid_i = 1'b0;
      #1;
      chk1("stray_valid_mreq", mem_req_o, 1'b0);
      fetch(32'h0000_5000, 1, 1'b0, -1);

      // Random traffic over a few sets and tags checked against the model.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         int lat;
         bit h;
         a   = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(0, 2)) << 2);
         lat = int'($urandom_range(0, 3));
         if ($urandom_range(0, 11) == 0) begin
            idle_flush(a);
         end else begin
            h = model_hit(a);
            fetch(a, lat, h, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
         end
      end

      @(negedge clk_in);
      if_req_i = 1'b0;
      #1;
`ifdef ICACHE_STAT_EN
      chk32("end_hitcnt", hit_cnt_o, 32'(n_hit));
      chk32("end_misscnt", miss_cnt_o, 32'(n_miss));
`endif
      chk1("end_idle_mreq", mem_req_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
